// File: rtl/lakespec_config_loader_if.sv
// ----------------------------------------------------------------------------
// lakespec_config_loader_if
// Config bus between a host/config master and lakespec_config_loader.
//
// Handshake: config_write and config_read are single-cycle strobes that are
// always accepted. There is no ready or backpressure. A write consumes
// config_config_addr/config_config_data on the rising edge where config_write
// is high. A read samples config_config_addr on the rising edge where
// config_read is high, and config_read_data carries the result from the
// following cycle until the next read. flush is the same pulse that lakespec
// sees. It only matters to the loader while a commit is pending.
//
// Signals (master view):
//   flush                   out  flush pulse shared with lakespec
//   config_config_addr      out  word address (32)
//   config_config_data      out  write data (WORD_WIDTH)
//   config_write            out  write strobe
//   config_read             out  read strobe
//   config_read_data        in   registered readback word
//   config_memory_size_550  in   active config vector
//   config_valid            in   an active config has been committed
//   config_err              in   sticky error flag
//   state_dbg               in   loader FSM state (IDLE=0, LOADING=1, PENDING=2)
// ----------------------------------------------------------------------------
interface lakespec_config_loader_if #(
    parameter int CONFIG_WIDTH = 550,
    parameter int WORD_WIDTH   = 32
);
    logic                    flush;
    logic [31:0]             config_config_addr;
    logic [WORD_WIDTH-1:0]   config_config_data;
    logic                    config_write;
    logic                    config_read;
    logic [WORD_WIDTH-1:0]   config_read_data;
    logic [CONFIG_WIDTH-1:0] config_memory_size_550;
    logic                    config_valid;
    logic                    config_err;
    logic [1:0]              state_dbg;

    modport master (
        output flush, config_config_addr, config_config_data, config_write, config_read,
        input  config_read_data, config_memory_size_550, config_valid, config_err, state_dbg
    );

    modport slave (
        input  flush, config_config_addr, config_config_data, config_write, config_read,
        output config_read_data, config_memory_size_550, config_valid, config_err, state_dbg
    );
endinterface

// File: rtl/lakespec_config_loader.sv
// ----------------------------------------------------------------------------
// lakespec_config_loader
// Assembles addressed 32-bit config writes into the lakespec static config
// vector. Writes land in a shadow copy. The active copy seen by lakespec only
// changes on a flush after the host has filled every word and armed the commit
// through the control word. lakespec therefore never sees a partial config.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  lakespec_config_loader_if.slave (write/read bus, flush, active config,
//        valid/err status, FSM state debug)
//
// Address map: 0..NUM_WORDS-1 are shadow words, CTRL_ADDR is control/status,
// and any other address is an error on write and reads as 0.
// Control write: bit0 arms the commit, bit1 clears err.
// Status read: {pad, mask[NUM_WORDS-1:0], err, state[1:0], valid}.
// ----------------------------------------------------------------------------
module lakespec_config_loader #(
    parameter int          CONFIG_WIDTH = 550,
    parameter int          WORD_WIDTH   = 32,
    parameter logic [31:0] CTRL_ADDR    = 32'h0000_00FF
) (
    input  logic                      clk,
    input  logic                      rst,
    lakespec_config_loader_if.slave   bus
);
    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    // Number of config bits that live in the final, partial word.
    localparam int LAST_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        PENDING = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
    logic [CONFIG_WIDTH-1:0] active_q, active_d;
    logic [NUM_WORDS-1:0]    mask_q, mask_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [WORD_WIDTH-1:0]   read_data_q, read_data_d;

    // Address decode
    logic             is_data, is_ctrl;
    logic [IDX_W-1:0] word_idx;
    logic             is_last_word;
    logic             data_wr, ctrl_wr, bad_wr;
    logic             mask_full;
    logic             commit;
    logic             err_set;

    assign is_data      = bus.config_config_addr < 32'(NUM_WORDS);
    assign is_ctrl      = bus.config_config_addr == CTRL_ADDR;
    assign word_idx     = bus.config_config_addr[IDX_W-1:0];
    assign is_last_word = word_idx == IDX_W'(NUM_WORDS - 1);
    assign data_wr      = bus.config_write && is_data;
    assign ctrl_wr      = bus.config_write && is_ctrl;
    assign bad_wr       = bus.config_write && !is_data && !is_ctrl;
    assign mask_full    = &mask_q;
    assign commit       = (state_q == PENDING) && bus.flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            mask_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            mask_q      <= mask_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_wr) state_d = LOADING;
            LOADING: if (ctrl_wr && bus.config_config_data[0] && mask_full) state_d = PENDING;
            PENDING: if (bus.flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        mask_d      = mask_q;
        valid_d     = valid_q;
        err_d       = err_q;
        read_data_d = read_data_q;
        err_set     = 1'b0;

        // The shadow is frozen once a commit is armed.
        if (data_wr && state_q != PENDING) begin
            if (is_last_word) begin
                shadow_d[CONFIG_WIDTH-1 -: LAST_BITS] = bus.config_config_data[LAST_BITS-1:0];
            end else begin
                shadow_d[int'(word_idx)*WORD_WIDTH +: WORD_WIDTH] = bus.config_config_data;
            end
            mask_d[word_idx] = 1'b1;
        end

        if (data_wr && state_q == PENDING) err_set = 1'b1;
        if (bad_wr) err_set = 1'b1;
        // Arming without a complete shadow is rejected. Arming while already
        // pending is harmless and ignored.
        if (ctrl_wr && bus.config_config_data[0] &&
            (state_q == IDLE || (state_q == LOADING && !mask_full))) err_set = 1'b1;

        if (err_set) err_d = 1'b1;
        // Clear wins over any set caused by the same control write.
        if (ctrl_wr && bus.config_config_data[1]) err_d = 1'b0;

        if (commit) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
            mask_d   = '0;
        end

        // Reads see the register contents from before any same-cycle write.
        if (bus.config_read) begin
            if (is_data) begin
                if (is_last_word) begin
                    read_data_d = {{(WORD_WIDTH-LAST_BITS){1'b0}}, shadow_q[CONFIG_WIDTH-1 -: LAST_BITS]};
                end else begin
                    read_data_d = shadow_q[int'(word_idx)*WORD_WIDTH +: WORD_WIDTH];
                end
            end else if (is_ctrl) begin
                read_data_d = {{(WORD_WIDTH-NUM_WORDS-4){1'b0}}, mask_q, err_q, state_q, valid_q};
            end else begin
                read_data_d = '0;
            end
        end
    end

    assign bus.config_read_data       = read_data_q;
    assign bus.config_memory_size_550 = active_q;
    assign bus.config_valid           = valid_q;
    assign bus.config_err             = err_q;
    assign bus.state_dbg              = state_q;
endmodule

// File: tb/tb_lakespec_config_loader.sv
module tb_lakespec_config_loader;
    localparam logic [31:0] CTRL = 32'h0000_00FF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    lakespec_config_loader_if bus_if ();

    lakespec_config_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        fl;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  exp_state;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic exp_err, input logic [1:0] exp_state,
                                input logic exp_valid);
        check({name, "_err"},   {31'b0, bus_if.config_err},   {31'b0, exp_err});
        check({name, "_state"}, {30'b0, bus_if.state_dbg},    {30'b0, exp_state});
        check({name, "_valid"}, {31'b0, bus_if.config_valid}, {31'b0, exp_valid});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.config_write       = 1'b0;
        bus_if.config_read        = 1'b0;
        bus_if.flush              = 1'b0;
        bus_if.config_config_addr = '0;
        bus_if.config_config_data = '0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        bus_if.config_write       = 1'b1;
        bus_if.config_config_addr = addr;
        bus_if.config_config_data = data;
        step();
        idle_bus();
    endtask

    task automatic rd_word(input logic [31:0] addr);
        bus_if.config_read        = 1'b1;
        bus_if.config_config_addr = addr;
        step();
        idle_bus();
    endtask

    task automatic flush_pulse();
        bus_if.flush = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic add(input logic wr, input logic rd, input logic fl,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic chk_rd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic [1:0] exp_state, input logic exp_valid);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.addr = addr; v.data = data;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.exp_err = exp_err; v.exp_state = exp_state; v.exp_valid = exp_valid;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_bus();

        // Vector table. It starts from the IDLE state after the T1 commit.
        // T2: partial load, early arm rejected, complete, arm with err clear
        for (int i = 0; i < 17; i++)
            add(1, 0, 0, 32'(i), 32'h2000 + 32'(i), 0, 0, 0, 2'd1, 1);
        add(1, 0, 0, CTRL, 32'h1, 0, 0, 1, 2'd1, 1);
        add(1, 0, 0, 32'd17, 32'hFFFF_FFC5, 0, 0, 1, 2'd1, 1);
        add(1, 0, 0, CTRL, 32'h3, 0, 0, 0, 2'd2, 1);
        add(0, 1, 0, CTRL, 0, 1, 32'h003F_FFF5, 0, 2'd2, 1);
        // T3: write while pending is ignored and flagged, then commit
        add(1, 0, 0, 32'd3, 32'h0000_DEAD, 0, 0, 1, 2'd2, 1);
        add(0, 1, 0, 32'd3, 0, 1, 32'h0000_2003, 1, 2'd2, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 1);            // flush in IDLE: no effect
        add(1, 0, 0, CTRL, 32'h2, 0, 0, 0, 2'd0, 1);       // clear err
        add(1, 0, 0, CTRL, 32'h1, 0, 0, 1, 2'd0, 1);       // arm with empty mask
        add(1, 0, 0, CTRL, 32'h3, 0, 0, 0, 2'd0, 1);       // clear beats same-write set
        // T4: read-during-write returns old data
        add(1, 0, 0, 32'd5, 32'h0000_1234, 0, 0, 0, 2'd1, 1);
        add(1, 1, 0, 32'd5, 32'h0000_BEEF, 1, 32'h0000_1234, 0, 2'd1, 1);
        add(0, 1, 0, 32'd5, 0, 1, 32'h0000_BEEF, 0, 2'd1, 1);
        add(1, 0, 0, 32'd17, 32'hFFFF_FFFF, 0, 0, 0, 2'd1, 1);
        add(0, 1, 0, 32'd17, 0, 1, 32'h0000_003F, 0, 2'd1, 1);
        // T5: unmapped address
        add(1, 0, 0, 32'h40, 32'h1, 0, 0, 1, 2'd1, 1);
        add(0, 1, 0, 32'h40, 0, 1, 32'h0, 1, 2'd1, 1);
        add(0, 1, 0, CTRL, 0, 1, 32'h0020_020B, 1, 2'd1, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0020_020B, 1, 2'd1, 1); // read_data holds

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 2'd0, 0);
        check("reset_rdata", bus_if.config_read_data, 32'h0);
        check("reset_active", {31'b0, |bus_if.config_memory_size_550}, 32'h0);
        rst = 1'b0;
        step();

        // T1: full load and commit
        for (int i = 0; i < 18; i++) wr_word(32'(i), 32'h1000 + 32'(i));
        check_status("t1_loaded", 0, 2'd1, 0);
        wr_word(CTRL, 32'h1);
        check_status("t1_armed", 0, 2'd2, 0);
        check("t1_active_pre", {31'b0, |bus_if.config_memory_size_550}, 32'h0);
        step();
        check_status("t1_hold", 0, 2'd2, 0);
        flush_pulse();
        check_status("t1_commit", 0, 2'd0, 1);
        check("t1_w0",  bus_if.config_memory_size_550[31:0],    32'h1000);
        check("t1_w1",  bus_if.config_memory_size_550[63:32],   32'h1001);
        check("t1_w16", bus_if.config_memory_size_550[543:512], 32'h1010);
        check("t1_w17", {26'b0, bus_if.config_memory_size_550[549:544]}, 32'h11);
        rd_word(CTRL);
        check("t1_status", bus_if.config_read_data, 32'h1);

        // Table-driven vectors T2..T5
        foreach (vecs[i]) begin
            bus_if.config_write       = vecs[i].wr;
            bus_if.config_read        = vecs[i].rd;
            bus_if.flush              = vecs[i].fl;
            bus_if.config_config_addr = vecs[i].addr;
            bus_if.config_config_data = vecs[i].data;
            step();
            check_status($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_state, vecs[i].exp_valid);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), bus_if.config_read_data, vecs[i].exp_rd);
        end
        idle_bus();

        // Active holds the T3 commit despite later shadow writes
        check("t3_w0",  bus_if.config_memory_size_550[31:0],    32'h2000);
        check("t3_w3",  bus_if.config_memory_size_550[127:96],  32'h2003);
        check("t3_w5",  bus_if.config_memory_size_550[191:160], 32'h2005);
        check("t3_w17", {26'b0, bus_if.config_memory_size_550[549:544]}, 32'h05);

        // T6: reset while pending after a prior commit
        for (int i = 0; i < 18; i++) wr_word(32'(i), 32'hA500 + 32'(i));
        wr_word(CTRL, 32'h3);
        check_status("t6_armed", 0, 2'd2, 1);
        #2 rst = 1'b1;
        #1;
        check_status("t6_async", 0, 2'd0, 0);
        check("t6_async_active", {31'b0, |bus_if.config_memory_size_550}, 32'h0);
        step();
        check_status("t6_rst", 0, 2'd0, 0);
        check("t6_rst_rdata", bus_if.config_read_data, 32'h0);
        rst = 1'b0;
        step();
        rd_word(CTRL);
        check("t6_status", bus_if.config_read_data, 32'h0);
        rd_word(32'd4);
        check("t6_shadow4", bus_if.config_read_data, 32'h0);
        flush_pulse();
        check_status("t6_flush", 0, 2'd0, 0);
        check("t6_flush_active", {31'b0, |bus_if.config_memory_size_550}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
